// File: rtl/xnor_cmp_pipe.sv
// xnor_cmp_pipe: registered bitwise XOR/XNOR comparator on a valid/ready stream.
// One pipeline register, 1-cycle latency, full throughput.
// Also reports parity, equality, mismatch popcount and a saturating equal count.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          upstream handshake (in_ready is combinational)
//   in_a, in_b, in_mode        operands; mode 0 = XOR, 1 = XNOR
//   out_valid/out_ready        downstream handshake
//   out_y, out_par, out_eq     mode-applied word, its parity, a == b
//   out_diff                   number of differing bit positions
//   clr_cnt, match_cnt         sync clear / saturating count of equal transfers
module xnor_cmp_pipe #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned DIF_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_par,
  output logic             out_eq,
  output logic [DIF_W-1:0] out_diff,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             accept_c, xfer_c;
  logic [WIDTH-1:0] xor_c, y_c;
  logic [DIF_W-1:0] diff_c;
  logic             eq_c, par_c;

  // Output register is free, or is being drained this cycle
  assign in_ready  = !out_valid || out_ready;
  assign out_valid = (state_q == FULL);
  assign accept_c  = in_valid && in_ready;
  assign xfer_c    = out_valid && out_ready;

  // Result datapath
  always_comb begin
    xor_c  = in_a ^ in_b;
    y_c    = in_mode ? ~xor_c : xor_c;
    diff_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      diff_c = diff_c + DIF_W'(xor_c[i]);
    end
    eq_c  = (diff_c == '0);
    par_c = ^y_c;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state: fill on accept, drain on transfer without a refill
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept_c) state_d = FULL;
      FULL:    if (xfer_c && !accept_c) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Data registers load only on accept and otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_y    <= '0;
      out_par  <= 1'b0;
      out_eq   <= 1'b0;
      out_diff <= '0;
    end else if (accept_c) begin
      out_y    <= y_c;
      out_par  <= par_c;
      out_eq   <= eq_c;
      out_diff <= diff_c;
    end
  end

  // Equal-transfer counter: clear wins over increment, saturates at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (clr_cnt) begin
      match_cnt <= '0;
    end else if (xfer_c && out_eq && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_xnor_cmp_pipe.sv
// Self-checking bench for xnor_cmp_pipe (WIDTH=8, CNT_W=2) against a
// queue-based transaction model.
module tb_xnor_cmp_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned DIF_W = 4;
  localparam int unsigned CMAX  = 3;

  typedef struct packed {
    logic [7:0] y;
    logic       par;
    logic       eq;
    logic [3:0] diff;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_mode;
  logic [WIDTH-1:0] in_a, in_b;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_par, out_eq;
  logic [DIF_W-1:0] out_diff;
  logic             clr_cnt;
  logic [CNT_W-1:0] match_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t q[$];
  res_t last;
  int   cnt;

  xnor_cmp_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_par(out_par), .out_eq(out_eq), .out_diff(out_diff),
    .clr_cnt(clr_cnt), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  function automatic res_t ref_res(input logic [7:0] a, input logic [7:0] b, input logic m);
    res_t r;
    r.y    = m ? ~(a ^ b) : (a ^ b);
    r.diff = 4'($countones(a ^ b));
    r.eq   = (a == b);
    r.par  = ($countones(r.y) % 2) == 1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".y"},     32'(out_y),     32'(last.y));
    chk({tag, ".par"},   32'(out_par),   32'(last.par));
    chk({tag, ".eq"},    32'(out_eq),    32'(last.eq));
    chk({tag, ".diff"},  32'(out_diff),  32'(last.diff));
    chk({tag, ".cnt"},   32'(match_cnt), 32'(cnt));
  endtask

  // One clock: drive inputs, check in_ready, advance model, clock, check outputs
  task automatic cycle(input string tag, input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic m, input logic ordy,
                       input logic clr);
    bit acc, xfer;
    in_valid = v; in_a = a; in_b = b; in_mode = m; out_ready = ordy; clr_cnt = clr;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'((q.size() == 0) || ordy));
    xfer = (q.size() != 0) && ordy;
    acc  = v && ((q.size() == 0) || ordy);
    if (clr) cnt = 0;
    else if (xfer && q[0].eq && cnt < CMAX) cnt++;
    if (xfer) void'(q.pop_front());
    if (acc) begin
      last = ref_res(a, b, m);
      q.push_back(last);
    end
    @(posedge clk); #1;
    chk_outs(tag);
  endtask

  task automatic model_reset();
    q.delete();
    last = '0;
    cnt  = 0;
  endtask

  initial begin
    logic [7:0] a, b;
    int neq;
    model_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_a = 8'h3C; in_b = 8'h5A; in_mode = 1'b0;
    out_ready = 1'b0; clr_cnt = 1'b0;

    // Reset with in_valid high
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk_outs("rst");
    rst_n = 1'b1;

    // First accept straight after reset release
    cycle("t1", 1, 8'hA5, 8'hA5, 1, 0, 0);
    chk("t1.y_const", 32'(out_y), 32'hFF);
    chk("t1.eq_const", 32'(out_eq), 32'd1);
    cycle("t1d", 0, 8'h00, 8'h00, 0, 1, 0);

    // Mode and popcount
    cycle("t2x", 1, 8'hF0, 8'h0F, 0, 1, 0);
    chk("t2x.diff_const", 32'(out_diff), 32'd8);
    cycle("t2n", 1, 8'hF0, 8'h0F, 1, 1, 0);
    chk("t2n.y_const", 32'(out_y), 32'h00);

    // Backpressure: three stalled cycles with new inputs offered
    for (int i = 0; i < 3; i++) cycle("t3s", 1, 8'($urandom), 8'($urandom), 1'($urandom), 0, 0);
    cycle("t3r", 1, 8'h12, 8'h34, 0, 1, 0);
    cycle("t3d", 0, 8'h00, 8'h00, 0, 1, 0);

    // Streaming 16 back-to-back pairs
    cycle("t4c", 0, 8'h00, 8'h00, 0, 1, 1);
    neq = 0;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      if (a == b) neq++;
      cycle("t4", 1, a, b, 1'($urandom), 1, 0);
    end
    cycle("t4f", 0, 8'h00, 8'h00, 0, 1, 0);
    chk("t4.cnt_sat", 32'(match_cnt), 32'((neq > 3) ? 3 : neq));

    // Counter saturation and clear priority
    cycle("t5c", 0, 8'h00, 8'h00, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom);
      cycle("t5", 1, a, a, 1'($urandom), 1, 0);
    end
    cycle("t5f", 1, 8'h77, 8'h77, 0, 1, 0);
    chk("t5.sat", 32'(match_cnt), 32'd3);
    cycle("t5clr", 0, 8'h00, 8'h00, 0, 1, 1);
    chk("t5.clr", 32'(match_cnt), 32'd0);

    // Randomized mix of valid, ready and clear
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 2) == 0) ? a : 8'($urandom);
      cycle("rnd", 1'($urandom_range(0, 3) != 0), a, b, 1'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    // Async reset while stalled with a nonzero count
    cycle("t6a", 1, 8'h11, 8'h11, 0, 1, 0);
    cycle("t6b", 1, 8'h22, 8'h22, 0, 1, 0);
    cycle("t6s", 1, 8'h33, 8'h44, 0, 0, 0);
    chk("t6.pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6.in_ready", 32'(in_ready), 32'd1);
    chk_outs("t6");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle("t6n", 1, 8'hC3, 8'h3C, 1, 1, 0);
    cycle("t6d", 0, 8'h00, 8'h00, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
